inst_fetch_ctrl: RTL
====================

Name: inst_fetch_ctrl

Overview:
- Consumer side of the PC register. Takes IF_PC and issues an instruction fetch on the SRAM-like instruction bus (req/addr/addr_ok/data_ok/rdata).
- Buffers the returned instruction and hands it to ID with a valid/ready handshake.
- Drives the PC write enable (IF_PCWr) back to the PC register.
- Handles flush/redirect, draining any in-flight bus response.

Parameters:
- ADDR_W, 32, fetch address / PC width
- DATA_W, 32, instruction width
- NOP_INST, 32'h0000_0000, instruction word presented with an address-error fetch

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- if_pc  in  ADDR_W  current PC from PC register
- pc_wr  out  1  to PC IF_PCWr; PC loads NPC at next edge
- flush  in  1  redirect (branch/exception); NPC holds target this cycle
- id_ready  in  1  ID accepts instruction this cycle
- if_valid  out  1  instruction buffer valid toward ID
- if_inst  out  DATA_W  buffered instruction
- if_inst_pc  out  ADDR_W  PC of buffered instruction
- if_adel  out  1  fetch address error (if_pc[1:0]!=0)
- inst_req  out  1  bus request
- inst_addr  out  ADDR_W  bus address; stable while inst_req && !inst_addr_ok
- inst_addr_ok  in  1  slave accepted address
- inst_data_ok  in  1  read data valid
- inst_rdata  in  DATA_W  read data

Behaviour:
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Extra regs: req_lock, req_addr, discard, buffer (inst, pc, adel).
- Reset (rst=0, async):
  - state=S_IDLE; req_lock=0; discard=0; buffer cleared to 0.
  - Outputs: inst_req=0, pc_wr=0, if_valid=0, if_inst=0, if_inst_pc=0, if_adel=0, inst_addr=0.
  - S_IDLE -> S_REQ unconditionally on first edge after release.
- S_REQ, request path:
  - inst_req=1 when if_pc[1:0]==0.
  - inst_addr = req_lock ? req_addr : if_pc.
  - If addr_ok=0: latch req_addr=if_pc, set req_lock=1. Address stays stable until accepted even if PC changes.
  - If addr_ok=1: go S_WAIT, clear req_lock.
- S_REQ, misaligned if_pc (if_pc[1:0]!=0, req_lock=0):
  - No bus request.
  - Load buffer {NOP_INST, if_pc, adel=1}; go S_HOLD next edge.
- S_WAIT: inst_req=0.
  - On data_ok with discard=0: load buffer {inst_rdata, request addr, adel=0}; go S_HOLD.
  - On data_ok with discard=1: drop the data, clear discard, go S_REQ.
- S_HOLD: if_valid=1 and buffer drives if_inst/if_inst_pc/if_adel.
  - On id_ready or flush: go S_REQ.
  - Otherwise hold all outputs stable.
- pc_wr is combinational: pc_wr = flush | (if_valid & id_ready). At most one PC update per cycle. New if_pc is visible the cycle S_REQ is entered.
- Flush in each state:
  - S_REQ with addr_ok same cycle: go S_WAIT, set discard=1.
  - S_REQ without addr_ok and req_lock=1: keep requesting locked address, set discard=1. Response is drained after acceptance.
  - S_REQ without addr_ok and req_lock=0: drop request, clear lock; next cycle requests new if_pc.
  - S_WAIT: set discard=1 (data_ok same cycle with flush → dropped, go S_REQ).
  - S_HOLD: drop buffer, go S_REQ.
  - if_valid is not masked combinationally by flush; ID kills its own input.
- Latency and throughput:
  - Zero-wait slave (addr_ok in T, data_ok in T+1): if_valid in T+2.
  - One instruction per 3 cycles minimum; one outstanding request maximum.
- Reset mid-transaction returns to S_IDLE. The bus slave is assumed reset concurrently; no drain.

Decomposition:
- Shared package (CPU defines): fetch FSM state enum, NOP_INST constant, PC reset address. RstEnable is already defined there.
- No sub-module is needed. Optional inst_fetch_buf (one-entry valid/ready buffer) if reused by a later prefetch queue.

Test Plan:
- Reset release, if_pc=0xBFC0_0000, zero-wait slave returning 0x2408_0001, id_ready=1:
  - inst_req in cycle 1, if_valid cycle 3 with if_inst=0x2408_0001, if_inst_pc=0xBFC0_0000, pc_wr=1 same cycle.
- Slave holds addr_ok=0 for 3 cycles while flush changes if_pc to 0xBFC0_0380:
  - inst_addr stays 0xBFC0_0000 until accepted; response dropped; next request to 0xBFC0_0380; if_valid only for 0xBFC0_0380.
- Flush during S_WAIT, data_ok 4 cycles later:
  - No if_valid for old data; next inst_req follows data_ok by 1 cycle.
- id_ready=0 for 5 cycles in S_HOLD:
  - if_valid, if_inst, if_inst_pc stable; pc_wr=0; no inst_req.
- if_pc=0xBFC0_0002:
  - No inst_req; if_valid with if_adel=1, if_inst=0x0000_0000, if_inst_pc=0xBFC0_0002.
- rst asserted in S_WAIT:
  - All outputs 0 immediately (async); after release, fetch restarts from S_IDLE.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// ============================================================================
// Module : inst_fetch_ctrl_pkg
// Brief  : Shared CPU fetch definitions (FSM states, NOP, reset PC)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_ctrl_pkg;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic [31:0] NOP_INST_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_ADDR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// Module : inst_fetch_ctrl
// Brief  : IF stage fetch control: SRAM-like bus request, one-entry buffer to ID
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pc_wr,
    input  logic              flush,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_inst_pc,
    output logic              if_adel,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata
);

    fetch_state_e      r_state,    w_state_nxt;
    logic              r_req_lock, w_req_lock_nxt;
    logic [ADDR_W-1:0] r_req_addr, w_req_addr_nxt;
    logic              r_discard,  w_discard_nxt;
    logic [DATA_W-1:0] r_buf_inst, w_buf_inst_nxt;
    logic [ADDR_W-1:0] r_buf_pc,   w_buf_pc_nxt;
    logic              r_buf_adel, w_buf_adel_nxt;

    logic              w_pc_aligned;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_valid;

    assign w_pc_aligned = (if_pc[1:0] == 2'b00);
    // A locked request keeps going even if the PC has since become misaligned
    assign w_req        = (r_state == S_REQ) && (r_req_lock || w_pc_aligned);
    assign w_addr       = r_req_lock ? r_req_addr : if_pc;
    assign w_valid      = (r_state == S_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_req_lock <= 1'b0;
            r_req_addr <= '0;
            r_discard  <= 1'b0;
            r_buf_inst <= '0;
            r_buf_pc   <= '0;
            r_buf_adel <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_lock <= w_req_lock_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_buf_pc   <= w_buf_pc_nxt;
            r_buf_adel <= w_buf_adel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_lock_nxt = r_req_lock;
        w_req_addr_nxt = r_req_addr;
        w_discard_nxt  = r_discard;
        w_buf_inst_nxt = r_buf_inst;
        w_buf_pc_nxt   = r_buf_pc;
        w_buf_adel_nxt = r_buf_adel;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (!w_req) begin
                    if (!flush) begin
                        w_buf_inst_nxt = NOP_INST;
                        w_buf_pc_nxt   = if_pc;
                        w_buf_adel_nxt = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (inst_addr_ok) begin
                    w_state_nxt    = S_WAIT;
                    w_req_lock_nxt = 1'b0;
                    w_req_addr_nxt = w_addr;
                    w_discard_nxt  = r_discard | flush;
                end else if (!(flush && !r_req_lock)) begin
                    // Not yet accepted: freeze the address; a flush here only marks the reply stale
                    w_req_lock_nxt = 1'b1;
                    w_req_addr_nxt = w_addr;
                    w_discard_nxt  = r_discard | flush;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (r_discard || flush) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_buf_inst_nxt = inst_rdata;
                        w_buf_pc_nxt   = r_req_addr;
                        w_buf_adel_nxt = 1'b0;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (flush) begin
                    w_discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (id_ready || flush) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign inst_req   = w_req;
    assign inst_addr  = (r_state == S_REQ) ? w_addr : '0;
    assign if_valid   = w_valid;
    assign if_inst    = r_buf_inst;
    assign if_inst_pc = r_buf_pc;
    assign if_adel    = r_buf_adel;
    assign pc_wr      = (rst != RST_ENABLE) && (flush || (w_valid && id_ready));

endmodule

`default_nettype wire
